// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_pkg
// Brief    : Shared types and defaults for the DDR burst controller slice.
// Revision : 1.0
// ============================================================================
package ddr_pkg;

    localparam int DDR_ADDR_WIDTH_DEF = 26;
    localparam int DDR_DATA_WIDTH_DEF = 128;
    localparam int RD_FIFO_DEPTH_DEF  = 8;

    // Credit, outstanding and FIFO occupancy all range over 0..depth inclusive.
    localparam int CREDIT_WIDTH_DEF = $clog2(RD_FIFO_DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_LOAD  = 2'd1,
        ST_WR_ISSUE = 2'd2,
        ST_RD_ISSUE = 2'd3
    } state_e;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_fifo
// Brief    : Synchronous FIFO for read-return beats; push and pop may coincide.
// Revision : 1.0
// ============================================================================
module ddr_rd_fifo
    import ddr_pkg::*;
#(
    parameter int  WIDTH = 128,
    parameter int  DEPTH = 8,
    localparam int c_cnt_w = credit_width(DEPTH)
) (
    input  logic               phy_clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   push_data_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   head_o,
    output logic [c_cnt_w-1:0] count_o,
    output logic               empty_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;

    // A push into a full FIFO with a simultaneous pop lands in the slot being
    // vacated; the popped word is read before the write takes effect.
    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_burst_ctrl
// Brief    : Burst master for the DDR local interface with credit-protected
//            read returns. Macro DDR_BURST_CTRL_RD_HSK_EN holds read requests
//            until local_ready; otherwise reads are single-cycle pulses.
// Revision : 1.0
// ============================================================================
module ddr_burst_ctrl
    import ddr_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = DDR_ADDR_WIDTH_DEF,
    parameter int DDR_DATA_WIDTH = DDR_DATA_WIDTH_DEF,
    parameter int LEN_WIDTH      = 4,
    parameter int RD_FIFO_DEPTH  = RD_FIFO_DEPTH_DEF
) (
    input  logic                      phy_clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [DDR_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DDR_DATA_WIDTH-1:0] wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DDR_DATA_WIDTH-1:0] rd_data,
    input  logic                      local_init_done,
    output logic [DDR_ADDR_WIDTH-1:0] local_address,
    output logic                      local_burstbegin,
    input  logic                      local_ready,
    output logic                      local_write_req,
    output logic [DDR_DATA_WIDTH-1:0] local_wdata,
    output logic                      local_read_req,
    input  logic [DDR_DATA_WIDTH-1:0] local_rdata,
    input  logic                      local_rdata_valid,
    output logic                      busy,
    output logic                      rd_err
);

    localparam int                  c_cred_w = credit_width(RD_FIFO_DEPTH);
    localparam logic [c_cred_w-1:0] c_depth  = c_cred_w'(RD_FIFO_DEPTH);

    state_e                    state_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      beat_q;
    logic [DDR_ADDR_WIDTH-1:0] addr_q;
    logic [DDR_DATA_WIDTH-1:0] wdata_q;
    logic [c_cred_w-1:0]       outstanding_q;
    logic [c_cred_w-1:0]       outstanding_d;
    logic                      run_q;
    logic                      rd_err_q;

    logic                      w_rd_req;
    logic                      w_rd_issue;
    logic                      w_pop;
    logic                      w_ret_ok;
    logic                      w_ret_bad;
    logic                      w_last_beat;
    logic                      w_fifo_empty;
    logic [c_cred_w-1:0]       w_fifo_count;
    logic [c_cred_w-1:0]       w_credits;

    // Every beat in flight or buffered holds one FIFO slot.
    assign w_credits   = c_depth - outstanding_q - w_fifo_count;
    assign w_rd_req    = (state_q == ST_RD_ISSUE) && (w_credits != '0);
    assign w_last_beat = (beat_q == len_q);

`ifdef DDR_BURST_CTRL_RD_HSK_EN
    assign w_rd_issue = w_rd_req && local_ready;
`else
    assign w_rd_issue = w_rd_req;
`endif

    assign w_pop     = rd_valid && rd_ready;
    assign w_ret_ok  = local_rdata_valid && (outstanding_q != '0);
    assign w_ret_bad = local_rdata_valid && (outstanding_q == '0);

    always_comb begin
        outstanding_d = outstanding_q;
        case ({w_rd_issue, w_ret_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            beat_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            outstanding_q <= '0;
            run_q         <= 1'b0;
            rd_err_q      <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            outstanding_q <= outstanding_d;
            if (w_ret_bad) begin
                rd_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_addr;
                        len_q   <= cmd_len;
                        beat_q  <= '0;
                        state_q <= cmd_write ? ST_WR_LOAD : ST_RD_ISSUE;
                    end
                end
                ST_WR_LOAD: begin
                    if (wr_valid) begin
                        wdata_q <= wr_data;
                        state_q <= ST_WR_ISSUE;
                    end
                end
                ST_WR_ISSUE: begin
                    if (local_ready) begin
                        if (w_last_beat) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            state_q <= ST_WR_LOAD;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    if (w_rd_issue) begin
                        if (w_last_beat) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ddr_rd_fifo #(
        .WIDTH (DDR_DATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .phy_clk     (phy_clk),
        .rst_n       (rst_n),
        .push_i      (w_ret_ok),
        .push_data_i (local_rdata),
        .pop_i       (w_pop),
        .head_o      (rd_data),
        .count_o     (w_fifo_count),
        .empty_o     (w_fifo_empty)
    );

    // run_q keeps cmd_ready low while reset is asserted and for the first edge.
    assign cmd_ready        = run_q && (state_q == ST_IDLE) && local_init_done;
    assign wr_ready         = (state_q == ST_WR_LOAD);
    assign local_write_req  = (state_q == ST_WR_ISSUE);
    assign local_read_req   = w_rd_req;
    assign local_burstbegin = (local_write_req || local_read_req) && (beat_q == '0);
    assign local_address    = addr_q;
    assign local_wdata      = wdata_q;
    assign rd_valid         = !w_fifo_empty;
    assign busy             = (state_q != ST_IDLE) || (outstanding_q != '0);
    assign rd_err           = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_burst_ctrl
// Brief    : Directed bench with a pseudo DDR model and expected-beat queues.
// Revision : 1.0
// ============================================================================
module tb_ddr_burst_ctrl;

    localparam int AW    = 26;
    localparam int DW    = 128;
    localparam int LW    = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam logic [AW-1:0] TOP_M2 = AW'(2**AW - 2);

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          bb;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } ret_t;

    logic          phy_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          local_init_done = 1'b1;
    logic [AW-1:0] local_address;
    logic          local_burstbegin;
    logic          local_ready = 1'b1;
    logic          local_write_req;
    logic [DW-1:0] local_wdata;
    logic          local_read_req;
    logic [DW-1:0] local_rdata = '0;
    logic          model_rvalid = 1'b0;
    logic          inj_stray = 1'b0;
    logic          local_rdata_valid;
    logic          busy;
    logic          rd_err;

    assign local_rdata_valid = model_rvalid | inj_stray;

    beat_t         exp_wr[$];
    beat_t         exp_ra[$];
    logic [DW-1:0] exp_rd[$];
    ret_t          pend[$];
    logic [DW-1:0] ddr_mem [int unsigned];
    logic [DW-1:0] ref_mem [int unsigned];

    int    cyc = 0;
    int    wr_acc_cnt = 0;
    int    rd_iss_cnt = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    int    n_total = 0;
    bit    ready_rand = 1'b0;
    beat_t mb;
    logic  rd_acc;

    always #5 phy_clk = ~phy_clk;

    ddr_burst_ctrl #(
        .DDR_ADDR_WIDTH (AW),
        .DDR_DATA_WIDTH (DW),
        .LEN_WIDTH      (LW),
        .RD_FIFO_DEPTH  (DEPTH)
    ) dut (
        .phy_clk           (phy_clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .local_init_done   (local_init_done),
        .local_address     (local_address),
        .local_burstbegin  (local_burstbegin),
        .local_ready       (local_ready),
        .local_write_req   (local_write_req),
        .local_wdata       (local_wdata),
        .local_read_req    (local_read_req),
        .local_rdata       (local_rdata),
        .local_rdata_valid (local_rdata_valid),
        .busy              (busy),
        .rd_err            (rd_err)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pseudo DDR: accepts requests seen at the coming edge, returns reads after LAT.
    always @(negedge phy_clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            model_rvalid = 1'b0;
            local_ready  = 1'b1;
        end else begin
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                model_rvalid = 1'b1;
                local_rdata  = ddr_mem.exists(32'(pend[0].addr)) ? ddr_mem[32'(pend[0].addr)] : '0;
                void'(pend.pop_front());
            end else begin
                model_rvalid = 1'b0;
            end
            local_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (local_write_req && local_ready) begin
                wr_acc_cnt++;
                check("wr_expected", DW'(exp_wr.size() != 0), DW'(1));
                if (exp_wr.size() != 0) begin
                    mb = exp_wr.pop_front();
                    check("wr_addr", DW'(local_address), DW'(mb.addr));
                    check("wr_data", local_wdata, mb.data);
                    check("wr_burstbegin", DW'(local_burstbegin), DW'(mb.bb));
                end
                ddr_mem[32'(local_address)] = local_wdata;
            end
            rd_acc = local_read_req;
`ifdef DDR_BURST_CTRL_RD_HSK_EN
            rd_acc = rd_acc && local_ready;
`endif
            if (rd_acc) begin
                rd_iss_cnt++;
                check("rd_req_expected", DW'(exp_ra.size() != 0), DW'(1));
                if (exp_ra.size() != 0) begin
                    mb = exp_ra.pop_front();
                    check("rd_addr", DW'(local_address), DW'(mb.addr));
                    check("rd_burstbegin", DW'(local_burstbegin), DW'(mb.bb));
                end
                pend.push_back('{local_address, cyc + LAT});
            end
            if (rd_valid && rd_ready) begin
                check("rd_beat_expected", DW'(exp_rd.size() != 0), DW'(1));
                if (exp_rd.size() != 0) begin
                    check("rd_data", rd_data, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge phy_clk);
            done = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", DW'(done), DW'(1));
    endtask

    task automatic queue_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d0);
        logic [AW-1:0] ai;
        for (int i = 0; i <= int'(l); i++) begin
            ai = a + AW'(i);
            exp_wr.push_back('{ai, d0 + DW'(i), 1'(i == 0)});
            ref_mem[32'(ai)] = d0 + DW'(i);
        end
    endtask

    task automatic send_beats(input logic [LW-1:0] l, input logic [DW-1:0] d0);
        bit got;
        for (int i = 0; i <= int'(l); i++) begin
            got      = 1'b0;
            wr_valid = 1'b1;
            wr_data  = d0 + DW'(i);
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge phy_clk);
                got = wr_ready;
                tick();
            end
            wr_valid = 1'b0;
            check("wr_beat_taken", DW'(got), DW'(1));
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d0);
        queue_write(a, l, d0);
        send_cmd(1'b1, a, l);
        send_beats(l, d0);
    endtask

    task automatic start_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
        logic [AW-1:0] ai;
        for (int i = 0; i <= int'(l); i++) begin
            ai = a + AW'(i);
            exp_ra.push_back('{ai, '0, 1'(i == 0)});
            exp_rd.push_back(ref_mem[32'(ai)]);
        end
        send_cmd(1'b0, a, l);
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge phy_clk);
            #1;
            ok = !busy && !rd_valid && exp_wr.size() == 0 && exp_ra.size() == 0 && exp_rd.size() == 0;
        end
        check(tag, DW'(ok), DW'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int base;
        bit hit;

        // Reset state, with init_done already high.
        repeat (3) tick();
        check("rst_cmd_ready", DW'(cmd_ready), DW'(0));
        check("rst_wr_ready", DW'(wr_ready), DW'(0));
        check("rst_rd_valid", DW'(rd_valid), DW'(0));
        check("rst_write_req", DW'(local_write_req), DW'(0));
        check("rst_read_req", DW'(local_read_req), DW'(0));
        check("rst_burstbegin", DW'(local_burstbegin), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_rd_err", DW'(rd_err), DW'(0));
        check("rst_address", DW'(local_address), DW'(0));
        check("rst_wdata", local_wdata, DW'(0));
        check("rst_rd_data", rd_data, DW'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Four-beat write burst.
        do_write(AW'('h10), LW'(3), DW'('hA0));
        drain("wr_burst_done");
        check("wr_burst_accepts", DW'(wr_acc_cnt), DW'(4));
        check("wr_burst_busy", DW'(busy), DW'(0));

        // Read it back with the consumer always ready.
        rd_ready = 1'b1;
        base = rd_iss_cnt;
        start_read(AW'('h10), LW'(3));
        drain("rd_burst_done");
        check("rd_burst_issues", DW'(rd_iss_cnt - base), DW'(4));
        check("rd_burst_err", DW'(rd_err), DW'(0));

        // Sixteen-beat read with the consumer stalled: credits cap issue at depth.
        do_write(AW'('h20), LW'(15), DW'('hB0));
        drain("wr16_done");
        rd_ready = 1'b0;
        base = rd_iss_cnt;
        start_read(AW'('h20), LW'(15));
        repeat (30) tick();
        check("stall_issues", DW'(rd_iss_cnt - base), DW'(DEPTH));
        check("stall_read_req", DW'(local_read_req), DW'(0));
        check("stall_rd_valid", DW'(rd_valid), DW'(1));
        check("stall_busy", DW'(busy), DW'(1));
        rd_ready = 1'b1;
        drain("rd16_done");
        check("rd16_issues", DW'(rd_iss_cnt - base), DW'(16));
        check("rd16_err", DW'(rd_err), DW'(0));

        // Address wrap at the top line, with local_ready randomly stalling.
        ready_rand = 1'b1;
        base = wr_acc_cnt;
        do_write(TOP_M2, LW'(3), DW'('hC0));
        drain("wrap_wr_done");
        check("wrap_wr_accepts", DW'(wr_acc_cnt - base), DW'(4));
        ready_rand = 1'b0;
        start_read(TOP_M2, LW'(3));
        drain("wrap_rd_done");

        // Reset while beat 2 of a read burst is on the bus.
        rd_ready = 1'b0;
        base = rd_iss_cnt;
        start_read(AW'('h20), LW'(7));
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge phy_clk);
            #1;
            hit = (rd_iss_cnt - base == 3);
        end
        check("midrst_reached_beat2", DW'(hit), DW'(1));
        #1;
        rst_n = 1'b0;
        #1;
        exp_ra.delete();
        exp_rd.delete();
        check("midrst_read_req", DW'(local_read_req), DW'(0));
        check("midrst_rd_valid", DW'(rd_valid), DW'(0));
        check("midrst_busy", DW'(busy), DW'(0));
        check("midrst_cmd_ready", DW'(cmd_ready), DW'(0));
        check("midrst_address", DW'(local_address), DW'(0));
        check("midrst_burstbegin", DW'(local_burstbegin), DW'(0));
        rd_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("pre_stray_rd_err", DW'(rd_err), DW'(0));
        inj_stray = 1'b1;
        tick();
        inj_stray = 1'b0;
        tick();
        check("stray_rd_err", DW'(rd_err), DW'(1));
        check("stray_dropped", DW'(rd_valid), DW'(0));
        check("stray_busy", DW'(busy), DW'(0));

        // Command held off until the DDR reports init done.
        local_init_done = 1'b0;
        queue_write(AW'('h40), LW'(0), DW'('hD0));
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = AW'('h40);
        cmd_len   = LW'(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge phy_clk);
            check("init_low_cmd_ready", DW'(cmd_ready), DW'(0));
            tick();
        end
        local_init_done = 1'b1;
        @(negedge phy_clk);
        check("init_high_cmd_ready", DW'(cmd_ready), DW'(1));
        tick();
        cmd_valid = 1'b0;
        check("init_cmd_taken_wr_ready", DW'(wr_ready), DW'(1));
        send_beats(LW'(0), DW'('hD0));
        drain("init_wr_done");
        check("sticky_rd_err", DW'(rd_err), DW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
